pulse_seq_ctrl: RTL and testbench

//   Sequencer placed after the pulse-width measurement path. Consumes end-of-pulse

---
 rtl/pulse_seq_pkg.sv | 33 +++
 rtl/pulse_window_chk.sv | 23 ++
 rtl/pulse_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pulse_seq_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_seq_pkg.sv
// pulse_seq_pkg
//   Shared definitions for the pulse pattern sequencer:
//     - seq_state_e : sequencer state encoding (also driven out on seq_state)
//     - default nominal widths and timing constants
//     - tol_calc()  : tolerance in cycles from a nominal width and a percent rate
package pulse_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT1 = 3'd1,
        ST_WAIT2 = 3'd2,
        ST_WAIT3 = 3'd3,
        ST_CUT   = 3'd4,
        ST_LOCK  = 3'd5
    } seq_state_e;

    localparam int unsigned NOM1_DEF    = 500;
    localparam int unsigned NOM2_DEF    = 750;
    localparam int unsigned NOM3_DEF    = 1000;
    localparam int unsigned GAP_MAX_DEF = 20000;
    localparam int unsigned ACK_TO_DEF  = 1024;
    localparam int unsigned LOCKOUT_DEF = 50000;
    localparam int unsigned N_WIN       = 3;

    // nom*err/100, truncated. The product is kept to 15 bits: the largest
    // nominal (1000) times the largest rate (31) still fits.
    function automatic logic [15:0] tol_calc(input logic [15:0] nom, input logic [4:0] err);
        logic [14:0] prod;
        prod = 15'(nom * {11'd0, err});
        return {1'b0, prod / 15'd100};
    endfunction

endpackage

// File: rtl/pulse_window_chk.sv
// pulse_window_chk
//   Combinational inclusive window test: hit_o = (nom-tol <= width <= nom+tol),
//   16-bit unsigned. tol is always below nom, so the low bound cannot wrap.
// Ports
//   width_i  in  16  measured pulse width
//   nom_i    in  16  nominal width
//   tol_i    in  16  tolerance in cycles
//   hit_o    out 1   width lies inside the window
module pulse_window_chk (
    input  logic [15:0] width_i,
    input  logic [15:0] nom_i,
    input  logic [15:0] tol_i,
    output logic        hit_o
);

    logic [15:0] lo;
    logic [15:0] hi;

    assign lo    = nom_i - tol_i;
    assign hi    = nom_i + tol_i;
    assign hit_o = (width_i >= lo) && (width_i <= hi);

endmodule

// File: rtl/pulse_seq_ctrl.sv
// pulse_seq_ctrl
//   Matches a 3-pulse width pattern (with tolerance windows) from the pulse
//   measurement path, enforces an inter-pulse gap timeout, drives a cut
//   request/ack handshake with ack timeout, then holds a post-cut lockout.
// Ports
//   clk          in   1   system clock
//   rst          in   1   asynchronous reset, active-high
//   arm          in   1   1 = sequencing enabled; 0 forces IDLE
//   cfg_err_rate in   5   tolerance percent, latched when leaving IDLE
//   pulse_done   in   1   end-of-pulse strobe
//   pulse_width  in   16  measured width, valid with pulse_done
//   cut_ack      in   1   actuator acknowledge
//   cut_req      out  1   cut request, held until ack / timeout / disarm
//   seq_state    out  3   current state (debug)
//   seq_err      out  1   sticky ack-timeout error, cleared on re-arm
// Optional (macro PULSE_SEQ_STATS_EN)
//   cut_cnt      out  16  acknowledged cuts, saturating
//   miss_cnt     out  16  rejected pulses in WAIT2/WAIT3, saturating
module pulse_seq_ctrl
    import pulse_seq_pkg::*;
#(
    parameter int unsigned NOM1    = NOM1_DEF,
    parameter int unsigned NOM2    = NOM2_DEF,
    parameter int unsigned NOM3    = NOM3_DEF,
    parameter int unsigned GAP_MAX = GAP_MAX_DEF,
    parameter int unsigned ACK_TO  = ACK_TO_DEF,
    parameter int unsigned LOCKOUT = LOCKOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic [4:0]  cfg_err_rate,
    input  logic        pulse_done,
    input  logic [15:0] pulse_width,
    input  logic        cut_ack,
    output logic        cut_req,
    output logic [2:0]  seq_state,
    output logic        seq_err
`ifdef PULSE_SEQ_STATS_EN
    ,
    output logic [15:0] cut_cnt,
    output logic [15:0] miss_cnt
`endif
);

    // Timeouts fire on the edge where the shared timer holds LIMIT-1, i.e.
    // exactly LIMIT edges after the timer was cleared.
    localparam logic [15:0] GAP_LAST  = 16'(GAP_MAX - 1);
    localparam logic [15:0] ACK_LAST  = 16'(ACK_TO - 1);
    localparam logic [15:0] LOCK_LAST = 16'(LOCKOUT - 1);

    seq_state_e        state_q, state_d;
    logic [15:0]       timer_q, timer_d;
    logic              seq_err_q, seq_err_d;
    logic              cut_req_q, cut_req_d;
    logic              latch_tol;
    logic [N_WIN-1:0]  win_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_WIN; gi++) begin : g_win
            localparam int unsigned NOM = (gi == 0) ? NOM1 : (gi == 1) ? NOM2 : NOM3;
            localparam logic [15:0] NOM_W = 16'(NOM);

            logic [15:0] tol_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tol_q <= '0;
                end else if (latch_tol) begin
                    tol_q <= tol_calc(NOM_W, cfg_err_rate);
                end
            end

            pulse_window_chk u_chk (
                .width_i (pulse_width),
                .nom_i   (NOM_W),
                .tol_i   (tol_q),
                .hit_o   (win_hit[gi])
            );
        end
    endgenerate

    // The timer is cleared by default, so every state change and every
    // accepted pulse restarts it; only the waiting branches advance it.
    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        seq_err_d = seq_err_q;
        latch_tol = 1'b0;

        if (!arm) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_WAIT1;
                    latch_tol = 1'b1;
                    seq_err_d = 1'b0;
                end
                ST_WAIT1: begin
                    if (pulse_done && win_hit[0]) state_d = ST_WAIT2;
                end
                ST_WAIT2: begin
                    if (pulse_done) begin
                        // A miss that still fits window 1 restarts the pattern at pulse 2
                        if (win_hit[1])      state_d = ST_WAIT3;
                        else if (win_hit[0]) state_d = ST_WAIT2;
                        else                 state_d = ST_WAIT1;
                    end else if (timer_q >= GAP_LAST) begin
                        state_d = ST_WAIT1;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                ST_WAIT3: begin
                    if (pulse_done) begin
                        if (win_hit[2])      state_d = ST_CUT;
                        else if (win_hit[0]) state_d = ST_WAIT2;
                        else                 state_d = ST_WAIT1;
                    end else if (timer_q >= GAP_LAST) begin
                        state_d = ST_WAIT1;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                ST_CUT: begin
                    if (cut_ack) begin
                        state_d = ST_LOCK;
                    end else if (timer_q >= ACK_LAST) begin
                        state_d   = ST_LOCK;
                        seq_err_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                ST_LOCK: begin
                    if (timer_q >= LOCK_LAST) state_d = ST_WAIT1;
                    else                      timer_d = timer_q + 16'd1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // cut_req follows the next state so it rises on the edge that enters CUT
    // and falls on the edge that leaves it.
    assign cut_req_d = (state_d == ST_CUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            seq_err_q <= 1'b0;
            cut_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            seq_err_q <= seq_err_d;
            cut_req_q <= cut_req_d;
        end
    end

    assign seq_state = state_q;
    assign cut_req   = cut_req_q;
    assign seq_err   = seq_err_q;

`ifdef PULSE_SEQ_STATS_EN
    logic [15:0] cut_cnt_q;
    logic [15:0] miss_cnt_q;
    logic        cut_evt;
    logic        miss_evt;

    // arm=0 overrides both the ack and any pulse in the same cycle
    assign cut_evt  = arm && (state_q == ST_CUT) && cut_ack;
    assign miss_evt = arm && pulse_done &&
                      (((state_q == ST_WAIT2) && !win_hit[1]) ||
                       ((state_q == ST_WAIT3) && !win_hit[2]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cut_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (cut_evt && (cut_cnt_q != 16'hFFFF))   cut_cnt_q  <= cut_cnt_q + 16'd1;
            if (miss_evt && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign cut_cnt  = cut_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// tb_pulse_seq_ctrl
//   Directed scenarios plus randomized pulse traffic for pulse_seq_ctrl. A
//   timestamp-based reference model predicts state, cut_req and seq_err every
//   cycle. Build with PULSE_SEQ_STATS_EN to include the statistics ports.
module tb_pulse_seq_ctrl;

    localparam int GAP_MAX = 20000;
    localparam int ACK_TO  = 1024;
    // Shortened lockout keeps the run bounded; the lockout logic is length-agnostic.
    localparam int LOCKOUT = 5000;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic [4:0]  cfg_err_rate;
    logic        pulse_done;
    logic [15:0] pulse_width;
    logic        cut_ack;
    logic        cut_req;
    logic [2:0]  seq_state;
    logic        seq_err;
`ifdef PULSE_SEQ_STATS_EN
    logic [15:0] cut_cnt;
    logic [15:0] miss_cnt;
`endif

    always #5 clk = ~clk;

    pulse_seq_ctrl #(
        .LOCKOUT (LOCKOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .cfg_err_rate (cfg_err_rate),
        .pulse_done   (pulse_done),
        .pulse_width  (pulse_width),
        .cut_ack      (cut_ack),
        .cut_req      (cut_req),
        .seq_state    (seq_state),
        .seq_err      (seq_err)
`ifdef PULSE_SEQ_STATS_EN
        ,
        .cut_cnt      (cut_cnt),
        .miss_cnt     (miss_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: stage number (0 idle .. 5 lock), latched rate, sticky
    // error, and the cycle at which the current wait started.
    int noms[3] = '{500, 750, 1000};
    int m_st    = 0;
    int m_err   = 0;
    bit m_serr  = 1'b0;
    int cyc     = 0;
    int t_mark  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit in_win(input int nom, input int err, input int w);
        int tol;
        tol = nom * err / 100;
        return (w >= nom - tol) && (w <= nom + tol);
    endfunction

    task automatic model_update();
        int w;
        cyc++;
        w = int'(pulse_width);
        if (rst) begin
            m_st = 0; m_serr = 1'b0; m_err = 0;
            return;
        end
        if (!arm) begin
            m_st = 0;
            return;
        end
        case (m_st)
            0: begin m_st = 1; m_err = int'(cfg_err_rate); m_serr = 1'b0; end
            1: if (pulse_done && in_win(noms[0], m_err, w)) begin m_st = 2; t_mark = cyc; end
            2, 3: begin
                if (pulse_done) begin
                    if (in_win(noms[m_st-1], m_err, w)) begin m_st = m_st + 1; t_mark = cyc; end
                    else if (in_win(noms[0], m_err, w)) begin m_st = 2; t_mark = cyc; end
                    else m_st = 1;
                end else if (cyc - t_mark >= GAP_MAX) begin
                    m_st = 1;
                end
            end
            4: begin
                if (cut_ack) begin m_st = 5; t_mark = cyc; end
                else if (cyc - t_mark >= ACK_TO) begin m_st = 5; m_serr = 1'b1; t_mark = cyc; end
            end
            5: if (cyc - t_mark >= LOCKOUT) m_st = 1;
            default: m_st = 0;
        endcase
    endtask

    // One clock: advance the model on the edge, compare just after it.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("cycle", {27'd0, seq_state, cut_req, seq_err},
                       {27'd0, m_st[2:0], (m_st == 4), m_serr});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input int w);
        pulse_done  = 1'b1;
        pulse_width = 16'(w);
        step();
        pulse_done  = 1'b0;
        pulse_width = 16'($urandom_range(0, 65535));
        $display("txn pulse w=%0d -> state=%0d req=%0d err=%0d", w, seq_state, cut_req, seq_err);
    endtask

    task automatic rearm(input int e);
        arm = 1'b0;
        step();
        cfg_err_rate = 5'(e);
        arm = 1'b1;
        step();
    endtask

    task automatic pattern();
        pulse(500);
        pulse(750);
        pulse(1000);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int nomi;
        int span;

        rst = 1'b1; arm = 1'b0; cfg_err_rate = 5'd0;
        pulse_done = 1'b0; pulse_width = 16'd0; cut_ack = 1'b0;
        #2;
        check("reset_outputs", {27'd0, seq_state, cut_req, seq_err}, 32'd0);
        idle(2);
        rst = 1'b0;

        // 1: full pattern, ack after 5 cycles, lockout, back to WAIT1
        rearm(10);
        check("t1_wait1", 32'(seq_state), 32'd1);
        pulse(500);  idle(999);
        pulse(750);  idle(999);
        pulse(1000);
        check("t1_req_rise", 32'(cut_req), 32'd1);
        check("t1_state_cut", 32'(seq_state), 32'd4);
        idle(4);
        cut_ack = 1'b1;
        step();
        cut_ack = 1'b0;
        check("t1_req_fall", 32'(cut_req), 32'd0);
        check("t1_state_lock", 32'(seq_state), 32'd5);
        idle(LOCKOUT - 1);
        check("t1_lock_end", 32'(seq_state), 32'd5);
        step();
        check("t1_back_wait1", 32'(seq_state), 32'd1);

        // 2: window edges
        pulse(449); check("t2_449", 32'(seq_state), 32'd1);
        pulse(551); check("t2_551", 32'(seq_state), 32'd1);
        pulse(450); check("t2_450", 32'(seq_state), 32'd2);
        rearm(10);
        pulse(550); check("t2_550", 32'(seq_state), 32'd2);
        rearm(0);
        pulse(499); check("t2_e0_499", 32'(seq_state), 32'd1);
        pulse(501); check("t2_e0_501", 32'(seq_state), 32'd1);
        pulse(500); check("t2_e0_500", 32'(seq_state), 32'd2);

        // 3: resync
        rearm(10);
        pulse(500); pulse(500);
        check("t3_resync", 32'(seq_state), 32'd2);
        pulse(750); pulse(1000);
        check("t3_cut", 32'(cut_req), 32'd1);
        rearm(10);
        pulse(500); pulse(600);
        check("t3_drop", 32'(seq_state), 32'd1);

        // 4: gap timeout, then a pulse landing on the timeout cycle
        pulse(500);
        idle(GAP_MAX - 1);
        check("t4_before_to", 32'(seq_state), 32'd2);
        step();
        check("t4_timeout", 32'(seq_state), 32'd1);
        pulse(750);
        check("t4_750_rej", 32'(seq_state), 32'd1);
        pulse(500);
        idle(GAP_MAX - 1);
        pulse(750);
        check("t4_edge_accept", 32'(seq_state), 32'd3);

        // 5: ack timeout, seq_err sticky until re-arm
        rearm(10);
        pattern();
        idle(ACK_TO - 1);
        check("t5_req_held", 32'(cut_req), 32'd1);
        step();
        check("t5_req_drop", 32'(cut_req), 32'd0);
        check("t5_seq_err", 32'(seq_err), 32'd1);
        check("t5_lock", 32'(seq_state), 32'd5);
        arm = 1'b0; step();
        check("t5_err_kept", 32'(seq_err), 32'd1);
        arm = 1'b1; step();
        check("t5_err_clr", 32'(seq_err), 32'd0);

        // 6: disarm in WAIT3, in CUT, and disarm+ack together
        pulse(500); pulse(750);
        arm = 1'b0; step();
        check("t6_w3_idle", 32'(seq_state), 32'd0);
        rearm(10);
        pattern();
        arm = 1'b0; step();
        check("t6_cut_idle", 32'(seq_state), 32'd0);
        check("t6_cut_req", 32'(cut_req), 32'd0);
        rearm(10);
        pattern();
        arm = 1'b0; cut_ack = 1'b1; step();
        cut_ack = 1'b0;
        check("t6_prio_idle", 32'(seq_state), 32'd0);
`ifdef PULSE_SEQ_STATS_EN
        check("stats_cut_cnt", 32'(cut_cnt), 32'd1);
`endif
        rearm(10);
        pattern();
        #2;
        rst = 1'b1;
        #1;
        m_st = 0; m_serr = 1'b0; m_err = 0;
        check("t6_rst_req", 32'(cut_req), 32'd0);
        check("t6_rst_state", 32'(seq_state), 32'd0);
        #1;
        rst = 1'b0;

        // Random traffic against the model
        rearm($urandom_range(0, 31));
        for (int t = 0; t < 300; t++) begin
            if (m_st == 5 || $urandom_range(0, 19) == 0) rearm($urandom_range(0, 31));
            nomi = $urandom_range(0, 2);
            span = noms[nomi] * 31 / 100 + 4;
            w = noms[nomi] - span + int'($urandom_range(0, 2 * span));
            if ($urandom_range(0, 9) == 0) w = int'($urandom_range(0, 65535));
            cut_ack = ($urandom_range(0, 3) == 0);
            pulse(w);
            cut_ack = 1'b0;
            idle($urandom_range(0, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
